// File: rtl/ws2812_pkg.sv
// ws2812_pkg -- shared definitions for the WS2812 chain driver.
//   * FSM state encodings (RESET, IDLE, LOAD, DATA)
//   * bit-timing helper functions, all results in clk cycles
//   * per-channel brightness scaling helper (used only when
//     WS2812_BRIGHTNESS_EN is defined)
package ws2812_pkg;

   localparam logic [1:0] ST_RESET = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;
   localparam logic [1:0] ST_DATA  = 2'd3;

   // Full bit period, 1.25 us rounded up to whole cycles
   function automatic int t_period(input int clk_mhz);
      return (clk_mhz * 32'sd1250 + 32'sd999) / 32'sd1000;
   endfunction

   // High time of a '1' bit, 0.90 us rounded up
   function automatic int t_on(input int clk_mhz);
      return (clk_mhz * 32'sd900 + 32'sd999) / 32'sd1000;
   endfunction

   // High time of a '0' bit, 0.35 us rounded up
   function automatic int t_off(input int clk_mhz);
      return (clk_mhz * 32'sd350 + 32'sd999) / 32'sd1000;
   endfunction

   // Latch (end-of-frame) low time
   function automatic int t_reset(input int clk_mhz, input int reset_us);
      return clk_mhz * reset_us;
   endfunction

   // (c * (b + 1)) >> 8; the product never exceeds 16 bits
   function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] prod;
      prod = 16'(c) * (16'(b) + 16'd1);
      return 8'(prod >> 8);
   endfunction

endpackage

// File: rtl/ws2812_frame_buf.sv
// ws2812_frame_buf -- double-buffered LED frame memory.
// Two banks of NUM_LEDS words held in one RAM. Bank select sel_q names
// the front bank (read side); writes always go to the other (back) bank.
// The memory array and read register are never reset so contents survive
// a reset of the controller.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset (bank select only)
//   swap                : toggle bank select on this edge
//   we, wr_idx, wr_data : write into back[wr_idx] (caller range-checks wr_idx)
//   rd_en, rd_idx       : registered read of front[rd_idx]
//   rd_data             : read data, valid the cycle after rd_en
module ws2812_frame_buf
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 8,
   parameter int WIDTH    = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             swap,
   input  logic             we,
   input  logic [7:0]       wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [7:0]       rd_idx,
   output logic [WIDTH-1:0] rd_data
);

   localparam int DEPTH = 2 * NUM_LEDS;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [WIDTH-1:0] rd_data_q;
   logic             sel_q, sel_d;
   logic [AW-1:0]    wr_addr_s, rd_addr_s;

   // Bank select toggle and linear addresses (bank * NUM_LEDS + index)
   always_comb begin
      if (swap) begin
         sel_d = ~sel_q;
      end else begin
         sel_d = sel_q;
      end
      wr_addr_s = AW'(int'(~sel_q) * NUM_LEDS + int'(wr_idx));
      rd_addr_s = AW'(int'(sel_q) * NUM_LEDS + int'(rd_idx));
   end

   // Bank select register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sel_q <= 1'b0;
      end else begin
         sel_q <= sel_d;
      end
   end

   // RAM write and registered read; uses pre-swap sel_q so a write in the
   // swap cycle lands in the bank that becomes the new front
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr_s] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr_s];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/ws2812_multi.sv
// ws2812_multi -- WS2812 / SK6812 LED chain driver with double-buffered frame.
// Ports:
//   clk, reset_n         : single clock, synchronous active-low reset
//   write, led_num,      : store rgb_data into back bank at led_num
//   rgb_data               (indices >= NUM_LEDS are dropped)
//   commit               : request front/back swap at the next frame start
//   start, continuous    : one-shot frame trigger / auto-refresh
//   brightness           : global scale, used only with WS2812_BRIGHTNESS_EN
//   data                 : serial output line
//   busy, frame_done,    : status (registered)
//   swap_pending
// Optional feature macro: WS2812_BRIGHTNESS_EN (channel scaling by brightness).
// The serial line is a registered copy of the waveform of the previous
// cycle, so it trails the FSM by one cycle; bit lengths are unaffected.
module ws2812_multi
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS     = 8,
   parameter int BITS_PER_LED = 24,
   parameter int CLK_MHZ      = 12,
   parameter int T_RESET_US   = 280
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    write,
   input  logic [7:0]              led_num,
   input  logic [BITS_PER_LED-1:0] rgb_data,
   input  logic                    commit,
   input  logic                    start,
   input  logic                    continuous,
   input  logic [7:0]              brightness,
   output logic                    data,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    swap_pending
);

   localparam int T_PERIOD = t_period(CLK_MHZ);
   localparam int T_ON     = t_on(CLK_MHZ);
   localparam int T_OFF    = t_off(CLK_MHZ);
   localparam int T_RESET  = t_reset(CLK_MHZ, T_RESET_US);
   localparam int PW       = $clog2(T_PERIOD + 1);
   localparam int RW       = $clog2(T_RESET + 2);
   localparam int BIW      = $clog2(BITS_PER_LED);

   logic [1:0]              state_q, state_d;
   logic [RW-1:0]           rst_cnt_q, rst_cnt_d;
   logic [PW-1:0]           phase_q, phase_d;
   logic [BIW-1:0]          bit_q, bit_d;
   logic [7:0]              led_q, led_d;
   logic                    start_pend_q, start_pend_d;
   logic                    after_frame_q, after_frame_d;
   logic                    swap_pending_q, swap_pending_d;
   logic                    data_q, data_d;
   logic                    busy_q, busy_d;
   logic                    frame_done_q, frame_done_d;
   logic                    we_s, swap_s, rd_en_s, cur_bit_s;
   logic                    last_phase_s, last_bit_s, last_led_s;
   logic [7:0]              rd_idx_s;
   logic [BITS_PER_LED-1:0] rd_data_s, word_s;

   assign we_s = write && ({1'b0, led_num} < 9'(NUM_LEDS));

   ws2812_frame_buf #(
      .NUM_LEDS (NUM_LEDS),
      .WIDTH    (BITS_PER_LED)
   ) u_frame_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .swap    (swap_s),
      .we      (we_s),
      .wr_idx  (led_num),
      .wr_data (rgb_data),
      .rd_en   (rd_en_s),
      .rd_idx  (rd_idx_s),
      .rd_data (rd_data_s)
   );

`ifdef WS2812_BRIGHTNESS_EN
   logic [7:0] bright_q, bright_d;

   // Brightness is frozen for the whole frame at LOAD
   always_comb begin
      if (state_q == ST_LOAD) begin
         bright_d = brightness;
      end else begin
         bright_d = bright_q;
      end
   end

   // Frozen brightness register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bright_q <= 8'hFF;
      end else begin
         bright_q <= bright_d;
      end
   end

   // Scale every 8-bit channel of the word being sent
   always_comb begin
      word_s = rd_data_s;
      for (int ch = 0; ch < BITS_PER_LED / 8; ch++) begin
         word_s[ch*8 +: 8] = scale_chan(rd_data_s[ch*8 +: 8], bright_q);
      end
   end
`else
   logic brightness_unused_s;
   assign brightness_unused_s = ^brightness;

   // Words go out exactly as stored
   always_comb begin
      word_s = rd_data_s;
   end
`endif

   // FSM, bit/LED counters, prefetch, swap and output next-values
   always_comb begin
      last_phase_s   = (phase_q == PW'(T_PERIOD - 1));
      last_bit_s     = (bit_q == BIW'(BITS_PER_LED - 1));
      last_led_s     = (led_q == 8'(NUM_LEDS - 1));
      cur_bit_s      = word_s[BIW'(BITS_PER_LED - 1) - bit_q];
      state_d        = state_q;
      rst_cnt_d      = rst_cnt_q;
      phase_d        = phase_q;
      bit_d          = bit_q;
      led_d          = led_q;
      after_frame_d  = after_frame_q;
      frame_done_d   = 1'b0;
      rd_en_s        = 1'b0;
      rd_idx_s       = led_q + 8'd1;
      // A start outside IDLE is remembered for one frame
      if (start && (state_q != ST_IDLE)) begin
         start_pend_d = 1'b1;
      end else begin
         start_pend_d = start_pend_q;
      end
      case (state_q)
         ST_RESET: begin
            if (rst_cnt_q <= RW'(32'd1)) begin
               if (continuous || start_pend_q || start) begin
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               rst_cnt_d = rst_cnt_q - RW'(32'd1);
            end
         end
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_d  = ST_DATA;
            phase_d  = {PW{1'b0}};
            bit_d    = {BIW{1'b0}};
            led_d    = 8'd0;
            rd_en_s  = 1'b1;
            rd_idx_s = 8'd0;
         end
         ST_DATA: begin
            if (!last_phase_s) begin
               phase_d = phase_q + PW'(32'd1);
            end else begin
               phase_d = {PW{1'b0}};
               if (!last_bit_s) begin
                  bit_d = bit_q + BIW'(32'd1);
               end else begin
                  bit_d = {BIW{1'b0}};
                  if (!last_led_s) begin
                     // Fetch the next word on the last cycle of this LED so
                     // it is in the read register exactly when needed
                     led_d   = led_q + 8'd1;
                     rd_en_s = 1'b1;
                  end else begin
                     state_d       = ST_RESET;
                     rst_cnt_d     = RW'(T_RESET);
                     after_frame_d = 1'b1;
                     frame_done_d  = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d       = ST_RESET;
            rst_cnt_d     = RW'(T_RESET);
            after_frame_d = 1'b0;
         end
      endcase
      if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
         start_pend_d = 1'b0;
      end else begin
         start_pend_d = start_pend_d;
      end
      // Swap only on entry to LOAD; a commit in that same cycle counts
      swap_s = (state_d == ST_LOAD) && (state_q != ST_LOAD) && (swap_pending_q || commit);
      if (swap_s) begin
         swap_pending_d = 1'b0;
      end else begin
         swap_pending_d = swap_pending_q || commit;
      end
      busy_d = (state_d == ST_LOAD) || (state_d == ST_DATA) ||
               ((state_d == ST_RESET) && after_frame_d);
      data_d = (state_q == ST_DATA) &&
               (phase_q < (cur_bit_s ? PW'(T_ON) : PW'(T_OFF)));
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= ST_RESET;
         rst_cnt_q      <= RW'(T_RESET);
         phase_q        <= {PW{1'b0}};
         bit_q          <= {BIW{1'b0}};
         led_q          <= 8'd0;
         start_pend_q   <= 1'b0;
         after_frame_q  <= 1'b0;
         swap_pending_q <= 1'b0;
         data_q         <= 1'b0;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         rst_cnt_q      <= rst_cnt_d;
         phase_q        <= phase_d;
         bit_q          <= bit_d;
         led_q          <= led_d;
         start_pend_q   <= start_pend_d;
         after_frame_q  <= after_frame_d;
         swap_pending_q <= swap_pending_d;
         data_q         <= data_d;
         busy_q         <= busy_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign data         = data_q;
   assign busy         = busy_q;
   assign frame_done   = frame_done_q;
   assign swap_pending = swap_pending_q;

endmodule

// File: tb/tb_ws2812_multi.sv
// tb_ws2812_multi -- directed bench for ws2812_multi (NUM_LEDS=2, 12 MHz).
module tb_ws2812_multi;

   localparam int NL = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        write = 1'b0;
   logic [7:0]  led_num = 8'd0;
   logic [23:0] rgb_data = 24'd0;
   logic        commit = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic [7:0]  brightness = 8'hFF;
   logic        data, busy, frame_done, swap_pending;

   int checks = 0;
   int errors = 0;

   ws2812_multi #(
      .NUM_LEDS     (NL),
      .BITS_PER_LED (24),
      .CLK_MHZ      (12),
      .T_RESET_US   (280)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .write        (write),
      .led_num      (led_num),
      .rgb_data     (rgb_data),
      .commit       (commit),
      .start        (start),
      .continuous   (continuous),
      .brightness   (brightness),
      .data         (data),
      .busy         (busy),
      .frame_done   (frame_done),
      .swap_pending (swap_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] w0;
      logic [23:0] w1;
      logic [1:0]  wmask;
      logic        bad_wr;
      logic        cmt;
      logic [7:0]  bright;
      logic [23:0] e0;
      logic [23:0] e1;
   } vec_t;

   vec_t vecs [5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] exp_word(input logic [23:0] w, input logic [7:0] b);
      logic [23:0] r;
      r = w;
`ifdef WS2812_BRIGHTNESS_EN
      for (int ch = 0; ch < 3; ch++) begin
         logic [15:0] p;
         p = 16'(w[ch*8 +: 8]) * (16'(b) + 16'd1);
         r[ch*8 +: 8] = p[15:8];
      end
`endif
      return r;
   endfunction

   task automatic do_write(input logic [7:0] idx, input logic [23:0] w);
      write = 1'b1;
      led_num = idx;
      rgb_data = w;
      tick();
      write = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 10000) begin
         tick();
         n++;
      end
      check("wait_idle", busy, 1'b0);
   endtask

   // Decode 48 bits from the serial line; terr counts timing violations
   task automatic capture(output logic [47:0] bits, output int terr);
      int g, h, l;
      terr = 0;
      bits = 48'd0;
      g = 0;
      while (data !== 1'b1 && g < 5000) begin
         tick();
         g++;
      end
      if (g >= 5000) terr++;
      for (int i = 0; i < 48; i++) begin
         h = 0;
         while (data === 1'b1 && h < 20) begin
            tick();
            h++;
         end
         l = 0;
         while (data !== 1'b1 && l < 20) begin
            tick();
            l++;
         end
         bits = {bits[46:0], (h == 11)};
         if (h != 11 && h != 5) terr++;
         if (i < 47 && (h + l) != 15) terr++;
      end
   endtask

   initial begin
      logic [47:0] bits;
      int terr;
      int n;

      vecs[0] = '{w0:24'h800000, w1:24'hFF8001, wmask:2'b11, bad_wr:1'b0, cmt:1'b1,
                  bright:8'hFF, e0:24'h800000, e1:24'hFF8001};
      vecs[1] = '{w0:24'h123456, w1:24'hABCDEF, wmask:2'b11, bad_wr:1'b0, cmt:1'b0,
                  bright:8'h7F, e0:24'h800000, e1:24'hFF8001};
      vecs[2] = '{w0:24'h000000, w1:24'h000000, wmask:2'b00, bad_wr:1'b0, cmt:1'b1,
                  bright:8'hFF, e0:24'h123456, e1:24'hABCDEF};
      vecs[3] = '{w0:24'hC0FFEE, w1:24'h000000, wmask:2'b01, bad_wr:1'b1, cmt:1'b1,
                  bright:8'hFF, e0:24'hC0FFEE, e1:24'hFF8001};
      vecs[4] = '{w0:24'h000000, w1:24'h000000, wmask:2'b00, bad_wr:1'b0, cmt:1'b1,
                  bright:8'hFF, e0:24'h123456, e1:24'hABCDEF};

      // Reset state
      repeat (3) tick();
      check("rst_data", data, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", frame_done, 1'b0);
      check("rst_pend", swap_pending, 1'b0);
      reset_n = 1'b1;
      repeat (100) tick();
      check("post_rst_busy", busy, 1'b0);

      // Table: write / commit / start / decode frame
      for (int e = 0; e < 5; e++) begin
         wait_idle();
         brightness = vecs[e].bright;
         if (vecs[e].wmask[0]) do_write(8'd0, vecs[e].w0);
         if (vecs[e].wmask[1]) do_write(8'd1, vecs[e].w1);
         if (vecs[e].bad_wr) do_write(8'(NL), 24'h5A5A5A);
         if (vecs[e].cmt) begin
            commit = 1'b1;
            tick();
            commit = 1'b0;
         end
         check($sformatf("v%0d_pend_set", e), swap_pending, vecs[e].cmt);
         start = 1'b1;
         tick();
         start = 1'b0;
         capture(bits, terr);
         check($sformatf("v%0d_timing", e), terr, 0);
         check($sformatf("v%0d_frame", e), bits,
               {exp_word(vecs[e].e0, vecs[e].bright), exp_word(vecs[e].e1, vecs[e].bright)});
         check($sformatf("v%0d_pend_clr", e), swap_pending, 1'b0);
      end
      brightness = 8'hFF;

      // Continuous refresh: pulse width and period, then drop mid-frame
      wait_idle();
      continuous = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!frame_done && n < 6000) begin
         tick();
         n++;
      end
      check("cont_first_pulse", frame_done, 1'b1);
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("cont_width%0d", k), frame_done, 1'b0);
         n = 1;
         while (!frame_done && n < 6000) begin
            tick();
            n++;
         end
         check($sformatf("cont_period%0d", k), n, 2 * 24 * 15 + 1 + 3360);
      end
      repeat (3460) tick();
      continuous = 1'b0;
      n = 0;
      while (!frame_done && n < 1000) begin
         tick();
         n++;
      end
      check("drop_last_pulse", frame_done, 1'b1);
      n = 0;
      while (busy && n < 6000) begin
         tick();
         n++;
      end
      check("drop_reset_len", n, 3360);
      repeat (100) tick();
      check("drop_stays_idle", busy, 1'b0);

      // Commit and write in the swap cycle itself
      start = 1'b1;
      commit = 1'b1;
      write = 1'b1;
      led_num = 8'd1;
      rgb_data = 24'h00FF00;
      tick();
      start = 1'b0;
      commit = 1'b0;
      write = 1'b0;
      tick();
      check("swapcyc_pend", swap_pending, 1'b0);
      capture(bits, terr);
      check("swapcyc_timing", terr, 0);
      check("swapcyc_frame", bits, {24'hC0FFEE, 24'h00FF00});

      // Reset in the middle of DATA, then restart from the bank-0 front
      wait_idle();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (data !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      repeat (40) tick();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      check("mid_pend", swap_pending, 1'b1);
      repeat (58) tick();
      reset_n = 1'b0;
      tick();
      check("mid_rst_data", data, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", frame_done, 1'b0);
      check("mid_rst_pend", swap_pending, 1'b0);
      reset_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (!busy && n < 6000) begin
         tick();
         n++;
      end
      check("restart_latency", n, 3360);
      capture(bits, terr);
      check("restart_timing", terr, 0);
      check("restart_frame", bits, {24'h123456, 24'hABCDEF});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
